// File: rtl/lpc_record_sched.sv
// lpc_record_sched: buffers decoded LPC transactions in a small FIFO and
// serializes each one as a 9-byte record on a byte-wide valid/ready sink.
// Dropped transactions are reported by a 2-byte marker (0xFF, drop count)
// that is sent between records.
module lpc_record_sched #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  lpc_clock,
  input  logic                  lpc_reset,
  input  logic [3:0]            in_cyctype_dir,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_data,
  input  logic [3:0]            in_data_size,
  input  logic                  in_clock_enable,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            drop_count
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
  localparam int unsigned LAST_B = 8;

  typedef struct packed {
    logic [3:0]  ct_dir;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    MARK0 = 2'd2,
    MARK1 = 2'd3
  } state_t;

  state_t           state;
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             mark_pending;
  logic [63:0]      shreg;
  logic [3:0]       idx;
  logic [7:0]       snap;

  logic             empty_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             xfer_c;
  logic             mark_done_c;
  rec_t             in_rec_c;
  rec_t             head_c;

  // FIFO status and the handshake/push/pop decisions for this edge
  always_comb begin
    empty_c     = (wr_ptr == rd_ptr);
    full_c      = ((wr_ptr ^ rd_ptr) == PTR_W'(DEPTH));
    xfer_c      = out_valid & out_ready;
    pop_c       = (state == IDLE) & ~mark_pending & ~empty_c;
    push_c      = in_clock_enable & (~full_c | pop_c);
    drop_c      = in_clock_enable & ~push_c;
    mark_done_c = (state == MARK1) & xfer_c;
    in_rec_c    = '{ct_dir: in_cyctype_dir, size: in_data_size,
                    addr: in_addr, data: in_data};
    head_c      = mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  // Record storage; contents are invalidated by the pointers, not reset
  always_ff @(posedge lpc_clock) begin
    if (push_c) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_rec_c;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level + PTR_W'(push_c) - PTR_W'(pop_c);
    end
  end

  // Drop accounting; a drop on the marker's final edge starts a new count
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      drop_count   <= 8'd0;
      mark_pending <= 1'b0;
    end else if (mark_done_c) begin
      drop_count   <= drop_c ? 8'd1 : 8'd0;
      mark_pending <= drop_c;
    end else if (drop_c) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      mark_pending <= 1'b1;
    end
  end

  // Scheduler: markers win at record boundaries, records are never cut short
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      shreg     <= 64'd0;
      idx       <= 4'd0;
      snap      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mark_pending) begin
            state     <= MARK0;
            out_valid <= 1'b1;
            out_byte  <= 8'hFF;
            snap      <= drop_count;
          end else if (pop_c) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_byte  <= head_c[71:64];
            shreg     <= head_c[63:0];
            idx       <= 4'd0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        SEND: begin
          if (xfer_c) begin
            if (idx == 4'(LAST_B)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              idx      <= idx + 4'd1;
              out_byte <= shreg[63:56];
              shreg    <= {shreg[55:0], 8'h00};
            end
          end
        end
        MARK0: begin
          if (xfer_c) begin
            state    <= MARK1;
            out_byte <= snap;
          end
        end
        MARK1: begin
          if (xfer_c) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_record_sched.sv
// Directed bench for lpc_record_sched: single record, backpressure, overflow
// marker, coincident events, saturation and reset mid-record.
module tb_lpc_record_sched;

  localparam int unsigned DEPTH_LOG2 = 3;

  logic                lpc_clock = 1'b0;
  logic                lpc_reset;
  logic [3:0]          in_cyctype_dir;
  logic [31:0]         in_addr;
  logic [31:0]         in_data;
  logic [3:0]          in_data_size;
  logic                in_clock_enable;
  logic [7:0]          out_byte;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] fifo_level;
  logic [7:0]          drop_count;

  int errors = 0;
  int checks = 0;

  lpc_record_sched #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .lpc_clock       (lpc_clock),
    .lpc_reset       (lpc_reset),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_data_size    (in_data_size),
    .in_clock_enable (in_clock_enable),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_level      (fifo_level),
    .drop_count      (drop_count)
  );

  always #5 lpc_clock = ~lpc_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge lpc_clock);
    #1;
  endtask

  function automatic logic [71:0] rec_of(input int i);
    return {4'(i % 4), 4'(i), 32'h1000_0000 + 32'(i), 32'hA500_0000 ^ 32'(i)};
  endfunction

  function automatic logic [7:0] byte_of(input logic [71:0] r, input int i);
    return r[71 - 8*i -: 8];
  endfunction

  task automatic strobe_rec(input logic [71:0] r);
    in_cyctype_dir  = r[71:68];
    in_data_size    = r[67:64];
    in_addr         = r[63:32];
    in_data         = r[31:0];
    in_clock_enable = 1'b1;
    tick();
    in_clock_enable = 1'b0;
  endtask

  // Waits (bounded) for a valid byte with out_ready high, checks it, lets it transfer
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk(tag, 32'(out_byte), 32'(exp));
    tick();
  endtask

  task automatic expect_rec(input string tag, input logic [71:0] r);
    for (int i = 0; i < 9; i++) begin
      expect_byte($sformatf("%s_b%0d", tag, i), byte_of(r, i));
    end
  endtask

  task automatic do_reset();
    lpc_reset = 1'b0;
    repeat (2) tick();
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [71:0] r1;
    int          bidx;

    r1              = {4'h0, 4'h1, 32'h0000_7FE5, 32'h0000_006C};
    in_cyctype_dir  = 4'h0;
    in_addr         = 32'h0;
    in_data         = 32'h0;
    in_data_size    = 4'h0;
    in_clock_enable = 1'b0;
    out_ready       = 1'b0;
    lpc_reset       = 1'b0;

    // Reset values while reset is held
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_byte",  32'(out_byte), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop",  32'(drop_count), 0);
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    tick();

    // 1: single record, no backpressure, exact latency
    out_ready = 1'b1;
    strobe_rec(r1);
    chk("t1_level_n", 32'(fifo_level), 1);
    chk("t1_valid_n", 32'(out_valid), 0);
    tick();
    chk("t1_level_n1", 32'(fifo_level), 0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("t1_byte%0d", i), 32'(out_byte), 32'(byte_of(r1, i)));
      tick();
    end
    chk("t1_valid_end", 32'(out_valid), 0);

    // 2: backpressure, out_ready toggling; 17 cycles first byte to last transfer
    out_ready = 1'b0;
    strobe_rec(r1);
    tick();
    bidx = 0;
    for (int k = 0; k < 17; k++) begin
      out_ready = (k % 2 == 0);
      chk($sformatf("t2_valid_k%0d", k), 32'(out_valid), 1);
      chk($sformatf("t2_byte_k%0d", k), 32'(out_byte), 32'(byte_of(r1, bidx)));
      tick();
      if (out_ready) bidx++;
    end
    chk("t2_valid_end", 32'(out_valid), 0);

    // 3: overflow, marker FF 02, then the queued records in order
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) strobe_rec(rec_of(i));
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_drop",  32'(drop_count), 2);
    chk("t3_head",  32'(out_byte), 32'(byte_of(rec_of(0), 0)));
    out_ready = 1'b1;
    expect_rec("t3_r0", rec_of(0));
    expect_byte("t3_mark0", 8'hFF);
    expect_byte("t3_mark1", 8'h02);
    chk("t3_drop_clr", 32'(drop_count), 0);
    for (int i = 1; i < 9; i++) expect_rec($sformatf("t3_r%0d", i), rec_of(i));
    tick();
    chk("t3_level_end", 32'(fifo_level), 0);
    chk("t3_valid_end", 32'(out_valid), 0);

    // 4a: full FIFO in IDLE, strobe on the pop edge is accepted
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) strobe_rec(rec_of(20 + i));
    chk("t4a_level_fill", 32'(fifo_level), 8);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t4a_last_byte", 32'(out_byte), 32'(byte_of(rec_of(20), 8)));
    tick();
    chk("t4a_idle_valid", 32'(out_valid), 0);
    chk("t4a_idle_level", 32'(fifo_level), 8);
    out_ready = 1'b0;
    strobe_rec(rec_of(40));
    chk("t4a_level", 32'(fifo_level), 8);
    chk("t4a_drop",  32'(drop_count), 0);
    chk("t4a_head",  32'(out_byte), 32'(byte_of(rec_of(21), 0)));
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) expect_rec($sformatf("t4a_r%0d", i), rec_of(20 + i));
    expect_rec("t4a_new", rec_of(40));
    tick();
    chk("t4a_level_end", 32'(fifo_level), 0);

    // 4b: drop on the MARK1 transfer edge restarts the count at 1
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) strobe_rec(rec_of(50 + i));
    chk("t4b_drop1", 32'(drop_count), 1);
    out_ready = 1'b1;
    repeat (9) tick();
    chk("t4b_gap", 32'(out_valid), 0);
    tick();
    chk("t4b_m0", 32'(out_byte), 32'hFF);
    tick();
    chk("t4b_m1", 32'(out_byte), 32'h01);
    strobe_rec(rec_of(70));
    chk("t4b_drop_again", 32'(drop_count), 1);
    chk("t4b_valid_idle", 32'(out_valid), 0);
    chk("t4b_level", 32'(fifo_level), 8);
    tick();
    chk("t4b_m0b", 32'(out_byte), 32'hFF);
    chk("t4b_m0b_valid", 32'(out_valid), 1);
    tick();
    chk("t4b_m1b", 32'(out_byte), 32'h01);
    tick();
    chk("t4b_drop_clr", 32'(drop_count), 0);
    chk("t4b_valid_clr", 32'(out_valid), 0);
    for (int i = 1; i < 9; i++) expect_rec($sformatf("t4b_r%0d", i), rec_of(50 + i));
    tick();

    // 5: saturation of drop_count at 255
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) strobe_rec(rec_of(100 + i));
    chk("t5_drop_sat", 32'(drop_count), 255);
    chk("t5_level", 32'(fifo_level), 8);
    out_ready = 1'b1;
    expect_rec("t5_r0", rec_of(100));
    expect_byte("t5_mark0", 8'hFF);
    expect_byte("t5_mark1", 8'hFF);
    chk("t5_drop_clr", 32'(drop_count), 0);
    for (int i = 1; i < 9; i++) expect_rec($sformatf("t5_r%0d", i), rec_of(100 + i));
    tick();

    // 6: reset in the middle of a record discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe_rec(rec_of(200 + i));
    chk("t6_level", 32'(fifo_level), 4);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t6_byte4", 32'(out_byte), 32'(byte_of(rec_of(200), 4)));
    lpc_reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_level", 32'(fifo_level), 0);
    chk("t6_rst_byte",  32'(out_byte), 0);
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("t6_quiet%0d", k), 32'(out_valid), 0);
    end
    chk("t6_level_quiet", 32'(fifo_level), 0);
    strobe_rec(rec_of(250));
    expect_rec("t6_new", rec_of(250));
    tick();
    chk("t6_valid_end", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
